// File: rtl/ms_display_pkg.sv
// Shared types and constants for the millisecond display decoder:
// FSM states, saturation limit and active-low seven-segment codes.
package ms_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [13:0] MAX_VAL   = 14'd9999;

    // Segment order {g,f,e,d,c,b,a}, a segment is lit when its bit is 0.
    localparam logic [6:0] SEG_CODES [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/ms_display_decoder_seg7_decode.sv
// One BCD digit to active-low seven-segment pattern, with a blank override.
module seg7_decode
    import ms_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank wins; non-decimal nibbles also show blank rather than garbage.
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (bcd <= 4'd9) begin
            seg = SEG_CODES[bcd];
        end else begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/ms_display_decoder.sv
// Binary millisecond value to four static seven-segment displays via an
// iterative double-dabble conversion; all outputs update together at LOAD.
module ms_display_decoder
    import ms_display_pkg::*;
#(
    parameter int VAL_W         = 14,
    parameter int NUM_DIGITS    = 4,
    parameter int BLANK_LEADING = 1
)
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [VAL_W-1:0]        value_in,
    output logic [6:0]              hex0,
    output logic [6:0]              hex1,
    output logic [6:0]              hex2,
    output logic [6:0]              hex3,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    overflow,
    output logic                    busy
);

    localparam int         BCD_W     = 4 * NUM_DIGITS;
    localparam logic [3:0] CNT_START = 4'(VAL_W - 1);

    state_t             state_r;
    logic [VAL_W-1:0]   last_val_r;
    logic               first_r;
    logic [VAL_W-1:0]   bin_sr_r;
    logic               ovf_pend_r;
    logic [BCD_W-1:0]   bcd_acc_r;
    logic [3:0]         cnt_r;

    logic [BCD_W-1:0]   adj_s;
    logic [NUM_DIGITS-1:0] blank_s;
    logic               zero_above_s;
    logic [6:0]         seg_s [NUM_DIGITS];

    assign busy = (state_r != IDLE);

    // Add-3 correction on every BCD nibble that would exceed 9 after doubling.
    always_comb begin
        adj_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_acc_r[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = bcd_acc_r[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = bcd_acc_r[4*i +: 4];
            end
        end
    end

    // Leading-zero blanking: a digit blanks when it and every higher digit are 0.
    always_comb begin
        blank_s      = '0;
        zero_above_s = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above_s = zero_above_s && (bcd_acc_r[4*i +: 4] == 4'd0);
            if (BLANK_LEADING != 0) begin
                blank_s[i] = zero_above_s;
            end else begin
                blank_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        seg7_decode u_seg (
            .bcd   (bcd_acc_r[4*g +: 4]),
            .blank (blank_s[g]),
            .seg   (seg_s[g])
        );
    end

    // Conversion FSM and registered display outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            last_val_r <= '0;
            first_r    <= 1'b1;
            bin_sr_r   <= '0;
            ovf_pend_r <= 1'b0;
            bcd_acc_r  <= '0;
            cnt_r      <= 4'd0;
            bcd_out    <= '0;
            overflow   <= 1'b0;
            hex0       <= SEG_BLANK;
            hex1       <= SEG_BLANK;
            hex2       <= SEG_BLANK;
            hex3       <= SEG_BLANK;
        end else begin
            case (state_r)
                IDLE: begin
                    // Only the value present when idle is taken; changes seen while busy are dropped.
                    if ((value_in != last_val_r) || first_r) begin
                        last_val_r <= value_in;
                        first_r    <= 1'b0;
                        bin_sr_r   <= (value_in > MAX_VAL) ? MAX_VAL : value_in;
                        ovf_pend_r <= (value_in > MAX_VAL);
                        bcd_acc_r  <= '0;
                        cnt_r      <= CNT_START;
                        state_r    <= SHIFT;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                SHIFT: begin
                    bcd_acc_r <= {adj_s[BCD_W-2:0], bin_sr_r[VAL_W-1]};
                    bin_sr_r  <= {bin_sr_r[VAL_W-2:0], 1'b0};
                    cnt_r     <= cnt_r - 4'd1;
                    if (cnt_r == 4'd0) begin
                        state_r <= LOAD;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                LOAD: begin
                    bcd_out  <= bcd_acc_r;
                    overflow <= ovf_pend_r;
                    hex0     <= seg_s[0];
                    hex1     <= seg_s[1];
                    hex2     <= seg_s[2];
                    hex3     <= seg_s[3];
                    state_r  <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms_display_decoder.sv
// Scoreboard bench: a cycle-level behavioural model predicts which values get
// converted and the resulting display; a monitor checks every cycle.
module tb_ms_display_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] value_in = 14'd0;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic [15:0] bcd_out;
    logic        overflow, busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [6:0]  h0, h1, h2, h3;
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t exp_q [$];
    exp_t held;

    int          mdl_cnt   = 0;
    logic [13:0] mdl_last  = 14'd0;
    bit          mdl_first = 1'b1;
    bit          prev_busy = 1'b0;

    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    ms_display_decoder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .value_in (value_in),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .bcd_out  (bcd_out),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t reset_exp();
        exp_t e;
        e.h0 = 7'h7F; e.h1 = 7'h7F; e.h2 = 7'h7F; e.h3 = 7'h7F;
        e.bcd = 16'h0; e.ovf = 1'b0;
        return e;
    endfunction

    function automatic exp_t exp_of(int v);
        exp_t e;
        int   s, d0, d1, d2, d3;
        s  = (v > 9999) ? 9999 : v;
        d0 = s % 10; d1 = (s / 10) % 10; d2 = (s / 100) % 10; d3 = s / 1000;
        e.h0  = seg_tbl[d0];
        e.h1  = (s < 10)   ? 7'h7F : seg_tbl[d1];
        e.h2  = (s < 100)  ? 7'h7F : seg_tbl[d2];
        e.h3  = (s < 1000) ? 7'h7F : seg_tbl[d3];
        e.bcd = 16'((d3 << 12) | (d2 << 8) | (d1 << 4) | d0);
        e.ovf = (v > 9999);
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an idle converter takes the live value when it differs
    // from the last one taken (or right after reset), then stays busy 15 cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdl_cnt   = 0;
            mdl_last  = 14'd0;
            mdl_first = 1'b1;
            exp_q.delete();
        end else if (mdl_cnt == 0) begin
            if ((value_in != mdl_last) || mdl_first) begin
                exp_q.push_back(exp_of(int'(value_in)));
                mdl_last  = value_in;
                mdl_first = 1'b0;
                mdl_cnt   = 15;
            end
        end else begin
            mdl_cnt = mdl_cnt - 1;
        end
    end

    // Monitor: busy every cycle, pop on completion, display must hold otherwise.
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            prev_busy = 1'b0;
            held      = reset_exp();
        end else begin
            chk("busy", 32'(busy), 32'(mdl_cnt != 0));
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_load", 32'd1, 32'd0);
                end else begin
                    held = exp_q.pop_front();
                end
            end
            chk("hex0", 32'(hex0), 32'(held.h0));
            chk("hex1", 32'(hex1), 32'(held.h1));
            chk("hex2", 32'(hex2), 32'(held.h2));
            chk("hex3", 32'(hex3), 32'(held.h3));
            chk("bcd_out", 32'(bcd_out), 32'(held.bcd));
            chk("overflow", 32'(overflow), 32'(held.ovf));
            prev_busy = busy;
        end
    end

    task automatic set_val(int v, int hold);
        @(negedge clk);
        value_in = 14'(v);
        repeat (hold) @(negedge clk);
    endtask

    int vals [6] = '{1234, 7, 1000, 10000, 16383, 9999};
    int v, sel, wait_cyc;

    initial begin
        held = reset_exp();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hex0", 32'(hex0), 32'h7F);
        chk("rst_bcd", 32'(bcd_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        foreach (vals[i]) set_val(vals[i], 18);

        // Changes while busy: only the last one gets converted afterwards.
        set_val(4, 3);
        set_val(5, 0);
        set_val(6, 0);
        set_val(8, 40);

        // Reset mid-conversion, then the same value must be reconverted.
        set_val(4321, 5);
        reset_n = 1'b0;
        #1;
        chk("midrst_hex3", 32'(hex3), 32'h7F);
        chk("midrst_hex0", 32'(hex0), 32'h7F);
        chk("midrst_bcd", 32'(bcd_out), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_4321_bcd", 32'(bcd_out), 32'h4321);

        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0:       v = $urandom_range(0, 9);
                1:       v = $urandom_range(0, 9999);
                2:       v = $urandom_range(10000, 16383);
                3:       v = int'(value_in);
                default: v = $urandom_range(0, 16383);
            endcase
            set_val(v, $urandom_range(0, 18));
        end

        wait_cyc = 0;
        while ((exp_q.size() != 0 || busy) && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
